input_sweep_sequencer: RTL and testbench

//   Synthesizable stimulus stage that drives the nine single-bit inputs (a..i) of the test block.

---
 rtl/input_sweep_sequencer.sv | 142 ++++++++++++++
 tb/tb_input_sweep_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_sweep_sequencer.sv
// input_sweep_sequencer
//   Drives the nine single-bit inputs of the test block with a cumulative
//   thermometer sweep: line 0 first, one more line every STEP_CYCLES clocks,
//   then one settle step with all lines high before a one-cycle done pulse.
//   Optional feature macro: SWEEP_CAPTURE_EN. When defined, the block's x/y
//   response is logged once per step into x_hist/y_hist. When undefined, the
//   hist ports read constant zero and x_in/y_in are ignored.
module input_sweep_sequencer #(
   parameter int N_LINES     = 9,
   parameter int STEP_CYCLES = 1000,
   parameter int IDX_W       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [N_LINES-1:0] lines,
   output logic               busy,
   output logic               done,
   output logic [IDX_W-1:0]   step_idx,
   input  logic               x_in,
   input  logic               y_in,
   output logic [N_LINES:0]   x_hist,
   output logic [N_LINES:0]   y_hist
);

   localparam int               PS_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LINES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t          state;
   logic [PS_W-1:0] prescaler;
   logic            terminal;
   logic            accept;
   logic            run_tc;
   logic            settle_tc;

   // Decode the events shared by the sequencer and the capture logic
   // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
   always_comb begin
      terminal  = (prescaler == PS_LAST);
      accept    = (state == S_IDLE)   && start    && !abort;
      run_tc    = (state == S_RUN)    && terminal && !abort;
      settle_tc = (state == S_SETTLE) && terminal && !abort;
   end

   // Sweep sequencer: abort overrides everything, all outputs are registers
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         prescaler <= '0;
         lines     <= '0;
         step_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         state     <= S_IDLE;
         prescaler <= '0;
         lines     <= '0;
         step_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  state     <= S_RUN;
                  prescaler <= '0;
                  lines     <= '0;
                  step_idx  <= '0;
                  busy      <= 1'b1;
               end
            end
            S_RUN: begin
               prescaler <= terminal ? '0 : prescaler + 1'b1;
               if (run_tc) begin
                  for (int k = 0; k < N_LINES; k++) begin
                     if (step_idx == IDX_W'(k)) lines[k] <= 1'b1;
                  end
                  step_idx <= step_idx + 1'b1;
                  if (step_idx == IDX_LAST) state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               prescaler <= terminal ? '0 : prescaler + 1'b1;
               if (settle_tc) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SWEEP_CAPTURE_EN
   // Response log: slot k holds x/y seen while lines[k-1:0] were high
   // NOTE: the history is a small flop array, so it is reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_hist <= '0;
         y_hist <= '0;
      end else if (accept) begin
         x_hist <= '0;
         y_hist <= '0;
      end else if (run_tc) begin
         for (int k = 0; k < N_LINES; k++) begin
            if (step_idx == IDX_W'(k)) begin
               x_hist[k] <= x_in;
               y_hist[k] <= y_in;
            end
         end
      end else if (settle_tc) begin
         x_hist[N_LINES] <= x_in;
         y_hist[N_LINES] <= y_in;
      end
   end
`else
   // Capture disabled: history ports are tied off and the responses are dropped
   assign x_hist = '0;
   assign y_hist = '0;

   logic unused_response;
   assign unused_response = x_in ^ y_in;
`endif

endmodule

// File: tb/tb_input_sweep_sequencer.sv
// tb_input_sweep_sequencer
//   Two instances: dut0 with STEP_CYCLES=4 and dut1 with STEP_CYCLES=1.
//   Expected values come from a timeline model: after edge E0+t the number
//   of raised lines is min(t/S, N), busy is t < (N+1)*S, done is t == (N+1)*S.
//   Define SWEEP_CAPTURE_EN for both RTL and bench to check the response log.
module tb_input_sweep_sequencer;

   localparam int N  = 9;
   localparam int S0 = 4;
   localparam int S1 = 1;
   localparam int IW = 4;
`ifdef SWEEP_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic start0, abort0, start1, abort1;
   logic x_rand, y_rand, block_mode;
   logic x_in0, y_in0, x_in1, y_in1;

   logic [N-1:0]  lines0, lines1;
   logic          busy0, busy1, done0, done1;
   logic [IW-1:0] step_idx0, step_idx1;
   logic [N:0]    x_hist0, y_hist0, x_hist1, y_hist1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Test block model: x = AND of the lines, y = XOR of the lines
   assign x_in0 = block_mode ? (&lines0) : x_rand;
   assign y_in0 = block_mode ? (^lines0) : y_rand;
   assign x_in1 = block_mode ? (&lines1) : x_rand;
   assign y_in1 = block_mode ? (^lines1) : y_rand;

   input_sweep_sequencer #(.N_LINES(N), .STEP_CYCLES(S0), .IDX_W(IW)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .lines(lines0), .busy(busy0), .done(done0), .step_idx(step_idx0),
      .x_in(x_in0), .y_in(y_in0), .x_hist(x_hist0), .y_hist(y_hist0)
   );

   input_sweep_sequencer #(.N_LINES(N), .STEP_CYCLES(S1), .IDX_W(IW)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .lines(lines1), .busy(busy1), .done(done1), .step_idx(step_idx1),
      .x_in(x_in1), .y_in(y_in1), .x_hist(x_hist1), .y_hist(y_hist1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int raised(input int t, input int s);
      if (t < 0) return 0;
      return (t / s > N) ? N : t / s;
   endfunction

   function automatic logic [N-1:0] model_lines(input int t, input int s);
      return N'((1 << raised(t, s)) - 1);
   endfunction

   // One full sweep on dut<sel>, starting with an accepting edge E0 (t=0)
   task automatic sweep(input int sel, input bit hold, input bit blk, input string nm);
      int            s, len, k;
      logic [N:0]    ex_x, ex_y, eh_x, eh_y;
      logic [N-1:0]  prev, el, ol;
      logic          ob, od;
      logic [IW-1:0] os;
      logic [N:0]    ohx, ohy;
      s = (sel != 0) ? S1 : S0;
      len = (N + 1) * s;
      ex_x = '0;
      ex_y = '0;
      block_mode = blk;
      for (int t = 0; t <= len + 1; t++) begin
         x_rand = 1'($urandom);
         y_rand = 1'($urandom);
         if (sel != 0) start1 = (t == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom));
         else          start0 = (t == 0) ? 1'b1 : (hold ? 1'b1 : 1'($urandom));
         if (t > 0 && t <= len && (t % s) == 0) begin
            k = t / s - 1;
            prev = model_lines(t - 1, s);
            ex_x[k] = blk ? (&prev) : x_rand;
            ex_y[k] = blk ? (^prev) : y_rand;
         end
         tick();
         ol  = (sel != 0) ? lines1    : lines0;
         ob  = (sel != 0) ? busy1     : busy0;
         od  = (sel != 0) ? done1     : done0;
         os  = (sel != 0) ? step_idx1 : step_idx0;
         ohx = (sel != 0) ? x_hist1   : x_hist0;
         ohy = (sel != 0) ? y_hist1   : y_hist0;
         el = model_lines(t, s);
         eh_x = CAP ? ex_x : '0;
         eh_y = CAP ? ex_y : '0;
         checks += 6;
         if (ol !== el) begin
            errors++;
            $display("FAIL %s lines t=%0d got %h exp %h", nm, t, ol, el);
         end
         if (ob !== (t < len)) begin
            errors++;
            $display("FAIL %s busy t=%0d got %b exp %b", nm, t, ob, (t < len));
         end
         if (od !== (t == len)) begin
            errors++;
            $display("FAIL %s done t=%0d got %b exp %b", nm, t, od, (t == len));
         end
         if (os !== IW'(raised(t, s))) begin
            errors++;
            $display("FAIL %s step_idx t=%0d got %0d exp %0d", nm, t, os, raised(t, s));
         end
         if (ohx !== eh_x) begin
            errors++;
            $display("FAIL %s x_hist t=%0d got %h exp %h", nm, t, ohx, eh_x);
         end
         if (ohy !== eh_y) begin
            errors++;
            $display("FAIL %s y_hist t=%0d got %h exp %h", nm, t, ohy, eh_y);
         end
      end
      if (!hold) begin
         start0 = 1'b0;
         start1 = 1'b0;
      end
      block_mode = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      x_rand = 1'b0; y_rand = 1'b0; block_mode = 1'b0;
      repeat (2) tick();
      checks += 4;
      if ({lines0, busy0, done0, step_idx0} !== '0) begin
         errors++;
         $display("FAIL reset dut0 outs got %h/%b/%b/%0d exp 0", lines0, busy0, done0, step_idx0);
      end
      if ({x_hist0, y_hist0} !== '0) begin
         errors++;
         $display("FAIL reset dut0 hist got %h/%h exp 0", x_hist0, y_hist0);
      end
      if ({lines1, busy1, done1, step_idx1} !== '0) begin
         errors++;
         $display("FAIL reset dut1 outs got %h/%b/%b/%0d exp 0", lines1, busy1, done1, step_idx1);
      end
      if ({x_hist1, y_hist1} !== '0) begin
         errors++;
         $display("FAIL reset dut1 hist got %h/%h exp 0", x_hist1, y_hist1);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sweep();
      sweep(0, 1'b0, 1'b0, "sweep");
      // lines holds all ones while idle after a completed sweep
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 2;
         if (lines0 !== {N{1'b1}}) begin
            errors++;
            $display("FAIL idle_hold lines i=%0d got %h exp %h", i, lines0, {N{1'b1}});
         end
         if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold busy/done i=%0d got %b/%b exp 0/0", i, busy0, done0);
         end
      end
   endtask

   task automatic test_back_to_back();
      sweep(0, 1'b1, 1'b0, "b2b_first");
      sweep(0, 1'b0, 1'b0, "b2b_second");
   endtask

   task automatic test_abort(input int t_ab, input string nm);
      int            len, k;
      logic [N:0]    ex_x, ex_y, eh_x, eh_y;
      logic [N-1:0]  el;
      logic          eb;
      len = (N + 1) * S0;
      ex_x = '0;
      ex_y = '0;
      block_mode = 1'b0;
      for (int t = 0; t <= t_ab + len; t++) begin
         x_rand = 1'($urandom);
         y_rand = 1'($urandom);
         start0 = (t == 0);
         abort0 = (t == t_ab);
         if (t > 0 && t < t_ab && (t % S0) == 0) begin
            k = t / S0 - 1;
            ex_x[k] = x_rand;
            ex_y[k] = y_rand;
         end
         tick();
         el = (t < t_ab) ? model_lines(t, S0) : '0;
         eb = (t < t_ab);
         eh_x = CAP ? ex_x : '0;
         eh_y = CAP ? ex_y : '0;
         checks += 5;
         if (lines0 !== el) begin
            errors++;
            $display("FAIL %s lines t=%0d got %h exp %h", nm, t, lines0, el);
         end
         if (busy0 !== eb) begin
            errors++;
            $display("FAIL %s busy t=%0d got %b exp %b", nm, t, busy0, eb);
         end
         if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s done t=%0d got %b exp 0", nm, t, done0);
         end
         if (step_idx0 !== ((t < t_ab) ? IW'(raised(t, S0)) : '0)) begin
            errors++;
            $display("FAIL %s step_idx t=%0d got %0d", nm, t, step_idx0);
         end
         if (x_hist0 !== eh_x || y_hist0 !== eh_y) begin
            errors++;
            $display("FAIL %s hist t=%0d got %h/%h exp %h/%h", nm, t, x_hist0, y_hist0, eh_x, eh_y);
         end
      end
      abort0 = 1'b0;
      start0 = 1'b0;
   endtask

   task automatic test_abort_start_idle();
      start0 = 1'b1;
      abort0 = 1'b1;
      tick();
      start0 = 1'b0;
      abort0 = 1'b0;
      checks += 1;
      if (busy0 !== 1'b0 || lines0 !== '0) begin
         errors++;
         $display("FAIL abort_wins busy/lines got %b/%h exp 0/0", busy0, lines0);
      end
      tick();
      checks += 1;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_queue busy got %b exp 0", busy0);
      end
   endtask

   task automatic test_async_reset();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (21) tick();
      checks += 1;
      if (lines0 !== model_lines(21, S0)) begin
         errors++;
         $display("FAIL async_pre lines got %h exp %h", lines0, model_lines(21, S0));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 2;
      if ({lines0, busy0, done0, step_idx0} !== '0) begin
         errors++;
         $display("FAIL async_rst outs got %h/%b/%b/%0d exp 0", lines0, busy0, done0, step_idx0);
      end
      if ({x_hist0, y_hist0} !== '0) begin
         errors++;
         $display("FAIL async_rst hist got %h/%h exp 0", x_hist0, y_hist0);
      end
      #2;
      rst_n = 1'b1;
      tick();
      sweep(0, 1'b0, 1'b0, "post_reset");
   endtask

   task automatic test_fast_step();
      sweep(1, 1'b0, 1'b0, "fast");
      sweep(1, 1'b0, 1'b1, "fast_block");
   endtask

   task automatic test_capture();
      sweep(0, 1'b0, 1'b1, "capture");
      checks += 2;
      if (x_hist0 !== (CAP ? 10'h200 : 10'h000)) begin
         errors++;
         $display("FAIL capture_final x_hist got %h exp %h", x_hist0, (CAP ? 10'h200 : 10'h000));
      end
      if (y_hist0 !== (CAP ? 10'h2AA : 10'h000)) begin
         errors++;
         $display("FAIL capture_final y_hist got %h exp %h", y_hist0, (CAP ? 10'h2AA : 10'h000));
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_back_to_back();
      test_abort(14, "abort14");
      test_abort(int'($urandom_range(1, (N + 1) * S0 - 1)), "abort_rand");
      test_abort_start_idle();
      test_async_reset();
      test_fast_step();
      test_capture();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
